imem_loader: RTL and testbench

Boot-time writer for the instruction memory the rv32 core fetches from. Accepts a byte stream (valid/ready) from a host link, assembles little-endian 32-bit instruction words and drives the imem write port. Holds the core in reset until the full image is written and its checksum verifies. Sits between the host byte source (UART RX or testbench) and imem/PC reset logic in the top level.

---
 rtl/imem_loader.sv | 162 ++++++++++++++++
 tb/tb_imem_loader.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory writer.
// Receives a framed byte stream (valid/ready), builds little-endian 32-bit
// words, writes them to imem and holds the core in reset until the whole
// image is written and its XOR checksum matches.
//
// Frame: N_lo, N_hi, N*4 data bytes (LSB first per word), checksum byte.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   i_byte/i_valid  incoming stream byte and its valid
//   o_ready         byte accepted when i_valid & o_ready at the rising edge
//   o_we            one-cycle imem write strobe per word
//   o_waddr/o_wdata imem byte address and word; hold last value when idle
//   o_hold          core reset request, released only after a good load
//   o_done/o_err    sticky load-complete / load-failed flags
//
// state   | meaning
// --------+--------------------------------------------------
// S_LEN0  | waiting for word-count low byte
// S_LEN1  | waiting for word-count high byte, range check
// S_DATA  | collecting the 4 bytes of the current word
// S_WRITE | one-cycle imem write of the assembled word
// S_CSUM  | waiting for the checksum byte
// S_DONE  | image loaded and verified, core released
// S_ERR   | oversize count or checksum mismatch
module imem_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  i_byte,
  input  logic        i_valid,
  output logic        o_ready,
  output logic        o_we,
  output logic [31:0] o_waddr,
  output logic [31:0] o_wdata,
  output logic        o_hold,
  output logic        o_done,
  output logic        o_err
);

  typedef enum logic [2:0] {
    S_LEN0  = 3'd0,
    S_LEN1  = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_CSUM  = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  localparam logic [16:0] DEPTH_L = 17'(DEPTH_WORDS);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_len;
  logic [15:0] r_k;
  logic [1:0]  r_byte_idx;
  logic [7:0]  r_acc;
  logic [23:0] r_asm;
  logic [31:0] r_waddr;
  logic [31:0] r_wdata;

  logic        w_xfer;
  logic [15:0] w_len_n;
  logic        w_oversize;
  logic [15:0] w_k_next;
  logic        w_last;

  assign w_xfer     = i_valid & o_ready;
  // full count as it will be once the high byte lands
  assign w_len_n    = {i_byte, r_len[7:0]};
  assign w_oversize = {1'b0, w_len_n} > DEPTH_L;
  assign w_k_next   = r_k + 16'd1;
  assign w_last     = (w_k_next == r_len);

  assign o_waddr = r_waddr;
  assign o_wdata = r_wdata;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_LEN0;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LEN0:  if (w_xfer) w_next = S_LEN1;
      S_LEN1: begin
        if (w_xfer) begin
          if (w_oversize)           w_next = S_ERR;
          else if (w_len_n == 16'd0) w_next = S_CSUM;
          else                      w_next = S_DATA;
        end
      end
      S_DATA:  if (w_xfer && r_byte_idx == 2'd3) w_next = S_WRITE;
      S_WRITE: w_next = w_last ? S_CSUM : S_DATA;
      S_CSUM: begin
        if (w_xfer) w_next = (i_byte == r_acc) ? S_DONE : S_ERR;
      end
      S_DONE:  w_next = S_DONE;
      S_ERR:   w_next = S_ERR;
      default: w_next = S_LEN0;
    endcase
  end

  always_comb begin
    o_ready = 1'b0;
    o_we    = 1'b0;
    o_hold  = 1'b1;
    o_done  = 1'b0;
    o_err   = 1'b0;
    case (r_state)
      S_LEN0, S_LEN1, S_DATA, S_CSUM: o_ready = 1'b1;
      S_WRITE: o_we = 1'b1;
      S_DONE: begin
        o_hold = 1'b0;
        o_done = 1'b1;
      end
      S_ERR:   o_err = 1'b1;
      default: o_hold = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_len      <= 16'd0;
      r_k        <= 16'd0;
      r_byte_idx <= 2'd0;
      r_acc      <= 8'd0;
      r_asm      <= 24'd0;
      r_waddr    <= 32'd0;
      r_wdata    <= 32'd0;
    end else begin
      // checksum byte itself is compared, never accumulated
      if (w_xfer && r_state != S_CSUM) r_acc <= r_acc ^ i_byte;
      case (r_state)
        S_LEN0: if (w_xfer) r_len[7:0]  <= i_byte;
        S_LEN1: if (w_xfer) r_len[15:8] <= i_byte;
        S_DATA: begin
          if (w_xfer) begin
            r_byte_idx <= r_byte_idx + 2'd1;
            case (r_byte_idx)
              2'd0: r_asm[7:0]   <= i_byte;
              2'd1: r_asm[15:8]  <= i_byte;
              2'd2: r_asm[23:16] <= i_byte;
              default: begin
                // word completes here so the WRITE cycle presents it directly
                r_wdata <= {i_byte, r_asm};
                r_waddr <= BASE_ADDR + {14'd0, r_k, 2'b00};
              end
            endcase
          end
        end
        S_WRITE: r_k <= w_k_next;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  i_byte = 8'd0;
  logic        i_valid = 1'b0;
  logic        o_ready, o_we, o_hold, o_done, o_err;
  logic [31:0] o_waddr, o_wdata;

  imem_loader #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .rst(rst), .i_byte(i_byte), .i_valid(i_valid),
    .o_ready(o_ready), .o_we(o_we), .o_waddr(o_waddr), .o_wdata(o_wdata),
    .o_hold(o_hold), .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  typedef struct {
    int n; bit fixed; bit bad; bit bp;
    bit exp_done; bit exp_err; int exp_nw;
  } vec_t;

  int vec_cnt = 0;
  int miss_cnt = 0;

  logic [7:0] frame_q[$];
  wr_t        got_q[$];
  wr_t        exp_q[$];
  int         exp_consumed;
  bit         exp_done, exp_err;
  logic [31:0] fixed_w [2];

  always @(negedge clk) begin
    if (o_we) got_q.push_back('{a: o_waddr, d: o_wdata});
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic build_frame(input int n, input bit fixed, input bit bad);
    logic [7:0]  c;
    logic [31:0] w;
    frame_q.delete();
    frame_q.push_back(8'(n));
    frame_q.push_back(8'(n >> 8));
    if (n > DEPTH) begin
      for (int i = 0; i < 3; i++) frame_q.push_back(8'($urandom));
      return;
    end
    for (int k = 0; k < n; k++) begin
      w = fixed ? fixed_w[k] : $urandom;
      for (int b = 0; b < 4; b++) frame_q.push_back(8'(w >> (8 * b)));
    end
    c = 8'd0;
    foreach (frame_q[i]) c ^= frame_q[i];
    frame_q.push_back(bad ? (c ^ 8'h01) : c);
  endtask

  // frame-level reference: what a correct loader does with frame_q
  task automatic model_frame();
    int          n;
    logic [7:0]  c;
    logic [31:0] w;
    exp_q.delete();
    n = int'(frame_q[0]) + 256 * int'(frame_q[1]);
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (n > DEPTH) begin
      exp_consumed = 2;
      exp_err = 1'b1;
      return;
    end
    for (int k = 0; k < n; k++) begin
      w = 32'd0;
      for (int b = 0; b < 4; b++) w += 32'(frame_q[2 + 4 * k + b]) << (8 * b);
      exp_q.push_back('{a: BASE + 32'(4 * k), d: w});
    end
    c = 8'd0;
    for (int i = 0; i < 2 + 4 * n; i++) c ^= frame_q[i];
    exp_consumed = 3 + 4 * n;
    exp_done = (frame_q[2 + 4 * n] == c);
    exp_err  = !exp_done;
  endtask

  task automatic offer(input bit bp, output int n_acc);
    int idx = 0;
    int stall = 0;
    bit v;
    n_acc = 0;
    while (idx < frame_q.size() && stall < 40) begin
      @(negedge clk);
      v = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      i_valid = v;
      i_byte  = frame_q[idx];
      if (v && o_ready) begin
        idx++;
        n_acc++;
        stall = 0;
      end else if (v) stall++;
      @(posedge clk);
    end
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    i_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("hold_in_reset", o_hold, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    got_q.delete();
  endtask

  task automatic chk_reset_state();
    chk("rst_ready", o_ready, 1'b1);
    chk("rst_we", o_we, 1'b0);
    chk("rst_waddr", o_waddr, 32'd0);
    chk("rst_wdata", o_wdata, 32'd0);
    chk("rst_hold", o_hold, 1'b1);
    chk("rst_done", o_done, 1'b0);
    chk("rst_err", o_err, 1'b0);
  endtask

  task automatic run_frame(input bit bp, input string nm);
    int n_acc;
    int nw;
    model_frame();
    offer(bp, n_acc);
    repeat (2) @(negedge clk);
    chk({nm, "_consumed"}, n_acc, exp_consumed);
    chk({nm, "_nwrites"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk({nm, "_waddr"}, got_q[i].a, exp_q[i].a);
      chk({nm, "_wdata"}, got_q[i].d, exp_q[i].d);
    end
    chk({nm, "_done"}, o_done, exp_done);
    chk({nm, "_err"}, o_err, exp_err);
    chk({nm, "_hold"}, o_hold, !exp_done);
    chk({nm, "_ready"}, o_ready, 1'b0);
    nw = got_q.size();
    for (int i = 0; i < 4; i++) begin
      i_valid = 1'b1;
      i_byte  = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
    end
    i_valid = 1'b0;
    chk({nm, "_post_nwrites"}, got_q.size(), nw);
    chk({nm, "_post_done"}, o_done, exp_done);
    chk({nm, "_post_err"}, o_err, exp_err);
  endtask

  initial begin
    vec_t        tbl [8];
    bit   [13:0] rdy_pat;
    bit   [13:0] we_pat;
    int          idx;
    int          wi;
    int          n_acc;
    int          budget;

    fixed_w[0] = 32'h0050_0093;
    fixed_w[1] = 32'h0010_8113;
    tbl[0] = '{n: 2,   fixed: 1, bad: 0, bp: 0, exp_done: 1, exp_err: 0, exp_nw: 2};
    tbl[1] = '{n: 0,   fixed: 0, bad: 0, bp: 0, exp_done: 1, exp_err: 0, exp_nw: 0};
    tbl[2] = '{n: 2,   fixed: 1, bad: 1, bp: 0, exp_done: 0, exp_err: 1, exp_nw: 2};
    tbl[3] = '{n: 257, fixed: 0, bad: 0, bp: 0, exp_done: 0, exp_err: 1, exp_nw: 0};
    tbl[4] = '{n: 2,   fixed: 1, bad: 0, bp: 1, exp_done: 1, exp_err: 0, exp_nw: 2};
    tbl[5] = '{n: 256, fixed: 0, bad: 0, bp: 0, exp_done: 1, exp_err: 0, exp_nw: 256};
    tbl[6] = '{n: 1,   fixed: 0, bad: 1, bp: 1, exp_done: 0, exp_err: 1, exp_nw: 1};
    tbl[7] = '{n: 65535, fixed: 0, bad: 0, bp: 0, exp_done: 0, exp_err: 1, exp_nw: 0};

    do_reset();
    chk_reset_state();

    // cycle-exact two-word load with i_valid held high
    rdy_pat = 14'b01011110111111;
    we_pat  = 14'b00100001000000;
    build_frame(2, 1'b1, 1'b0);
    idx = 0;
    wi  = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      i_valid = 1'b1;
      i_byte  = (idx < frame_q.size()) ? frame_q[idx] : 8'h00;
      chk("lat_ready", o_ready, rdy_pat[c]);
      chk("lat_we", o_we, we_pat[c]);
      if (we_pat[c] && wi < 2) begin
        chk("lat_waddr", o_waddr, BASE + 32'(4 * wi));
        chk("lat_wdata", o_wdata, fixed_w[wi]);
        wi++;
      end
      chk("lat_done", o_done, c == 13);
      if (o_ready) idx++;
      @(posedge clk);
    end
    @(negedge clk);
    i_valid = 1'b0;
    chk("lat_hold", o_hold, 1'b0);

    for (int t = 0; t < 8; t++) begin
      do_reset();
      build_frame(tbl[t].n, tbl[t].fixed, tbl[t].bad);
      run_frame(tbl[t].bp, $sformatf("tbl%0d", t));
      chk($sformatf("tbl%0d_exp_done", t), o_done, tbl[t].exp_done);
      chk($sformatf("tbl%0d_exp_err", t), o_err, tbl[t].exp_err);
      chk($sformatf("tbl%0d_exp_nw", t), got_q.size(), tbl[t].exp_nw);
    end

    // reset in the middle of a load, then a full resend
    do_reset();
    build_frame(2, 1'b1, 1'b0);
    idx = 0;
    budget = 0;
    while (idx < 6 && budget < 40) begin
      @(negedge clk);
      i_valid = 1'b1;
      i_byte  = frame_q[idx];
      if (o_ready) idx++;
      budget++;
      @(posedge clk);
    end
    chk("mid_sent6", idx, 6);
    @(negedge clk);
    rst = 1'b1;
    i_valid = 1'b0;
    chk("mid_hold_a", o_hold, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("mid_hold_b", o_hold, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("mid_hold_c", o_hold, 1'b1);
    rst = 1'b0;
    got_q.delete();
    chk_reset_state();
    run_frame(1'b0, "mid_rerun");

    // randomized frames against the reference model
    for (int r = 0; r < 20; r++) begin
      int  n;
      bit  bad;
      n   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(257, 65535)) : int'($urandom_range(0, 8));
      bad = ($urandom_range(0, 3) == 0);
      do_reset();
      build_frame(n, 1'b0, bad);
      run_frame(1'($urandom_range(0, 1)), $sformatf("rnd%0d", r));
    end

    n_acc = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
